motion_frame_sequencer: RTL

//  Frame-level controller wrapped around the background-subtract pixel stage.
//  - Sits between the bg/frame input FIFOs, the subtract stage and the output FIFO.
//  - Admits exactly one frame of pixels per start command and counts motion pixels.
//  - Reports completion and supports abort.

---
 rtl/motion_pkg.sv | 28 ++
 rtl/motion_pixel_counter.sv | 74 +++++++
 rtl/motion_frame_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
`default_nettype none
// ============================================================================
// Package     : motion_pkg
// Description : Shared types and constants for the motion frame sequencer.
//               Holds the sequencer state encoding and the binary pixel
//               values produced by the background-subtract stage.
// Revision    : 1.0 - initial release
// ============================================================================
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } seq_state_t;

    localparam logic [23:0] PIXEL_ON  = 24'hffffff;
    localparam logic [23:0] PIXEL_OFF = 24'h000000;

    // A subtract-stage pixel counts as motion only when it is fully on.
    function automatic logic is_pixel_on(input logic [23:0] pix);
        return (pix == PIXEL_ON);
    endfunction

endpackage
`default_nettype wire

// File: rtl/motion_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : motion_pixel_counter
// Description : Read, write and motion-pixel counters for one frame, plus
//               the write-side compares used by the sequencer FSM.
// Ports       : clk, rst        - clock, async active-high reset
//               i_clear         - zero all counters (frame start)
//               i_rd_inc        - count one pixel pair read
//               i_wr_inc        - count one pixel written
//               i_mot_inc       - count one motion pixel written
//               o_rd_cnt/o_wr_cnt/o_mot_cnt - current counts
//               o_wr_eq_n_nxt   - write count, including this cycle's write,
//                                 equals the frame size
//               o_wr_eq_rd      - registered write count equals read count
// Revision    : 1.0 - initial release
// ============================================================================
module motion_pixel_counter #(
    parameter int CNT_W = 4,
    parameter int N_PIX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_rd_inc,
    input  logic             i_wr_inc,
    input  logic             i_mot_inc,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic [CNT_W-1:0] o_wr_cnt,
    output logic [CNT_W-1:0] o_mot_cnt,
    output logic             o_wr_eq_n_nxt,
    output logic             o_wr_eq_rd
);

    localparam logic [CNT_W-1:0] C_N = N_PIX[CNT_W-1:0];

    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_mot_cnt;
    logic [CNT_W-1:0] w_wr_nxt;

    assign w_wr_nxt = r_wr_cnt + {{(CNT_W-1){1'b0}}, i_wr_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_mot_cnt <= '0;
        end else if (i_clear) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_mot_cnt <= '0;
        end else begin
            if (i_rd_inc) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (i_wr_inc) begin
                r_wr_cnt <= w_wr_nxt;
            end
            if (i_wr_inc && i_mot_inc) begin
                r_mot_cnt <= r_mot_cnt + 1'b1;
            end
        end
    end

    assign o_rd_cnt      = r_rd_cnt;
    assign o_wr_cnt      = r_wr_cnt;
    assign o_mot_cnt     = r_mot_cnt;
    // Looking at the post-write value lets DONE follow the last write by
    // a single cycle.
    assign o_wr_eq_n_nxt = (w_wr_nxt == C_N);
    assign o_wr_eq_rd    = (r_wr_cnt == r_rd_cnt);

endmodule
`default_nettype wire

// File: rtl/motion_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motion_frame_sequencer
// Description : Frame-level controller around the background-subtract stage.
//               Admits exactly one frame of pixels per start, counts motion
//               pixels, reports completion and supports abort.
// Ports       : clock, reset               - clock, async active-high reset
//               start, abort               - frame commands
//               busy, done, aborted        - status (done/aborted pulse)
//               motion_count, frame_id     - results of last completed frame
//               seq_err                    - sticky protocol error flag
//               bg/fr_empty_in/_out        - FIFO empties, gated to subtract
//               bg/fr_rd_en_in/_out        - read enables, gated to FIFOs
//               sub_wr_en, sub_din         - write path from subtract
//               out_full_in/_out           - output FIFO full, pass-through
//               out_wr_en, out_din         - write path to output FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module motion_frame_sequencer
    import motion_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
    parameter int FID_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] motion_count,
    output logic [FID_W-1:0] frame_id,
    output logic             seq_err,
    input  logic             bg_empty_in,
    input  logic             fr_empty_in,
    output logic             bg_empty_out,
    output logic             fr_empty_out,
    input  logic             bg_rd_en_in,
    input  logic             fr_rd_en_in,
    output logic             bg_rd_en_out,
    output logic             fr_rd_en_out,
    input  logic             sub_wr_en,
    input  logic [23:0]      sub_din,
    input  logic             out_full_in,
    output logic             out_full_out,
    output logic             out_wr_en,
    output logic [23:0]      out_din
);

    localparam int               C_N_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CNT_W-1:0] C_N     = C_N_PIX[CNT_W-1:0];

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic             w_clear;
    logic             w_run;
    logic             w_gate_open;
    logic             w_rd_fire;
    logic             w_mot_pix;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_wr_cnt;
    logic [CNT_W-1:0] w_mot_cnt;
    logic [CNT_W-1:0] w_rd_nxt;
    logic             w_wr_eq_n_nxt;
    logic             w_wr_eq_rd;
    logic             r_seq_err;
    logic [CNT_W-1:0] r_motion_count;
    logic [FID_W-1:0] r_frame_id;

    // ------------------------------------------------------------------
    // Read-side gating: the subtract stage only sees data while a frame
    // is running and fewer than N pixel pairs have been consumed.
    // ------------------------------------------------------------------
    assign w_run        = (r_state == RUN);
    assign w_gate_open  = w_run && (w_rd_cnt < C_N);
    assign bg_empty_out = w_gate_open ? bg_empty_in : 1'b1;
    assign fr_empty_out = w_gate_open ? fr_empty_in : 1'b1;
    assign bg_rd_en_out = bg_rd_en_in & w_run;
    assign fr_rd_en_out = fr_rd_en_in & w_run;
    assign w_rd_fire    = bg_rd_en_in & fr_rd_en_in & w_run;
    assign w_rd_nxt     = w_rd_cnt + {{(CNT_W-1){1'b0}}, w_rd_fire};

    // Write path is never gated so an in-flight pixel can always drain.
    assign out_full_out = out_full_in;
    assign out_wr_en    = sub_wr_en;
    assign out_din      = sub_din;
    assign w_mot_pix    = is_pixel_on(sub_din);

    motion_pixel_counter #(
        .CNT_W (CNT_W),
        .N_PIX (C_N_PIX)
    ) u_counter (
        .clk           (clock),
        .rst           (reset),
        .i_clear       (w_clear),
        .i_rd_inc      (w_rd_fire),
        .i_wr_inc      (sub_wr_en),
        .i_mot_inc     (w_mot_pix),
        .o_rd_cnt      (w_rd_cnt),
        .o_wr_cnt      (w_wr_cnt),
        .o_mot_cnt     (w_mot_cnt),
        .o_wr_eq_n_nxt (w_wr_eq_n_nxt),
        .o_wr_eq_rd    (w_wr_eq_rd)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        case (r_state)
            IDLE: begin
                // Abort has priority over a coincident start.
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = ABORT;
                end else if (w_rd_nxt == C_N) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = ABORT;
                end else if (w_wr_eq_n_nxt) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            ABORT: begin
                busy = 1'b1;
                // Every admitted pixel has been written back out.
                if (w_wr_eq_rd) begin
                    aborted     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Results and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_motion_count <= '0;
            r_frame_id     <= '0;
            r_seq_err      <= 1'b0;
        end else begin
            if (r_state == DONE) begin
                r_motion_count <= w_mot_cnt;
                r_frame_id     <= r_frame_id + 1'b1;
            end
            // Mismatched read enables, or a write with nothing outstanding.
            if ((bg_rd_en_in ^ fr_rd_en_in) || (sub_wr_en && w_wr_eq_rd)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign motion_count = r_motion_count;
    assign frame_id     = r_frame_id;
    assign seq_err      = r_seq_err;

endmodule
`default_nettype wire
